// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch front end: owns the fetch PC, keeps one imem read in
// flight, and buffers returned instructions for decode in a small FIFO.
module fetch_unit #(
  parameter int ADDR_W     = 64,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               CLK,
  input  logic               Reset_L,
  input  logic [ADDR_W-1:0]  StartPC,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC,
  output logic               ImemReqValid,
  output logic [ADDR_W-1:0]  ImemReqAddr,
  input  logic               ImemReqReady,
  input  logic               ImemRespValid,
  input  logic [INSTR_W-1:0] ImemRespData,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  InstrPC,
  input  logic               InstrReady
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  req_pc;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [INSTR_W-1:0] data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  pc_mem   [FIFO_DEPTH];
  logic               req_valid;
  logic               req_valid_next;
  logic               instr_valid;
  logic               instr_valid_next;
  logic               accept;
  logic               push;
  logic               pop;

  // A redirect flushes the buffer, so it also cancels any push or pop in that cycle.
  assign accept = req_valid && ImemReqReady;
  assign push   = ImemRespValid && (state == ST_WAIT) && !Redirect;
  assign pop    = (count != '0) && InstrReady && !Redirect;

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state <= ST_REQ;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_REQ: begin
        if (accept) begin
          next_state = Redirect ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ImemRespValid) begin
          next_state = ST_REQ;
        end else if (Redirect) begin
          next_state = ST_DROP;
        end
      end
      ST_DROP: begin
        if (ImemRespValid) begin
          next_state = ST_REQ;
        end
      end
      default: next_state = ST_REQ;
    endcase
  end

  // Request valid is registered from the next state and next occupancy, so the
  // credit rule holds without any input-to-output path.
  always_comb begin
    count_next = count;
    if (Redirect) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
    req_valid_next   = (next_state == ST_REQ) && (count_next < DEPTH_C);
    instr_valid_next = (count_next != '0);
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      fetch_pc    <= StartPC;
      req_pc      <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      req_valid   <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      if (Redirect) begin
        fetch_pc <= RedirectPC;
      end else if (accept) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (accept) begin
        req_pc <= fetch_pc;
      end
      if (Redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
      count       <= count_next;
      req_valid   <= req_valid_next;
      instr_valid <= instr_valid_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      data_mem[wr_ptr] <= ImemRespData;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

  assign ImemReqValid = req_valid;
  assign ImemReqAddr  = fetch_pc;
  assign InstrValid   = instr_valid;
  assign Instr        = data_mem[rd_ptr];
  assign InstrPC      = pc_mem[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-programmable instruction memory model plus
// request/instruction scoreboards filled from the expected fetch stream.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic [63:0] StartPC = '0;
  logic        Redirect = 1'b0;
  logic [63:0] RedirectPC = '0;
  logic        ImemReqValid;
  logic [63:0] ImemReqAddr;
  logic        ImemReqReady = 1'b0;
  logic        ImemRespValid = 1'b0;
  logic [31:0] ImemRespData = '0;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        InstrReady = 1'b0;

  int errors = 0;
  int checks = 0;

  bit          pend_v = 1'b0;
  logic [63:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          mem_lat = 1;
  bit          resp_seen = 1'b0;
  logic [63:0] resp_addr = '0;

  logic [63:0] exp_req[$];
  logic [63:0] exp_pc[$];

  fetch_unit #(
    .ADDR_W(64),
    .INSTR_W(32),
    .FIFO_DEPTH(2)
  ) dut (
    .CLK(CLK),
    .Reset_L(Reset_L),
    .StartPC(StartPC),
    .Redirect(Redirect),
    .RedirectPC(RedirectPC),
    .ImemReqValid(ImemReqValid),
    .ImemReqAddr(ImemReqAddr),
    .ImemReqReady(ImemReqReady),
    .ImemRespValid(ImemRespValid),
    .ImemRespData(ImemRespData),
    .InstrValid(InstrValid),
    .Instr(Instr),
    .InstrPC(InstrPC),
    .InstrReady(InstrReady)
  );

  initial forever #5 CLK = ~CLK;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_5A5A;
  endfunction

  // Memory model: at each negedge drive the due response, then capture any accept.
  task automatic drive_cycle(output bit acc);
    @(negedge CLK);
    if (pend_v && pend_cnt == 0) begin
      ImemRespValid = 1'b1;
      ImemRespData  = mem_data(pend_addr);
      resp_seen     = 1'b1;
      resp_addr     = pend_addr;
      pend_v        = 1'b0;
    end else begin
      ImemRespValid = 1'b0;
      ImemRespData  = '0;
      resp_seen     = 1'b0;
      if (pend_v) pend_cnt--;
    end
    ImemReqReady = 1'b1;
    acc = ImemReqValid;
    if (acc) begin
      pend_v    = 1'b1;
      pend_addr = ImemReqAddr;
      pend_cnt  = mem_lat - 1;
    end
  endtask

  task automatic do_reset(input logic [63:0] sp);
    @(negedge CLK);
    Reset_L       = 1'b0;
    StartPC       = sp;
    Redirect      = 1'b0;
    InstrReady    = 1'b0;
    ImemRespValid = 1'b0;
    pend_v        = 1'b0;
    mem_lat       = 1;
    repeat (2) @(negedge CLK);
    Reset_L = 1'b1;
    exp_req.delete();
    exp_pc.delete();
  endtask

  task automatic test_reset();
    do_reset(64'h100);
    checks++;
    if (ImemReqValid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_req_valid got=%b exp=0", ImemReqValid);
    end
    checks++;
    if (ImemReqAddr !== 64'h100) begin
      errors++; $display("[TB] FAIL reset_req_addr got=%h exp=%h", ImemReqAddr, 64'h100);
    end
    checks++;
    if (InstrValid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_instr_valid got=%b exp=0", InstrValid);
    end
    checks++;
    if (Instr !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_instr got=%h exp=0", Instr);
    end
    checks++;
    if (InstrPC !== 64'h0) begin
      errors++; $display("[TB] FAIL reset_instr_pc got=%h exp=0", InstrPC);
    end
  endtask

  task automatic test_sequential();
    bit acc;
    logic [63:0] e;
    int last_acc = -2;
    do_reset(64'h100);
    InstrReady = 1'b1;
    for (int i = 0; i < 9; i++) exp_req.push_back(64'h100 + 64'(4 * i));
    for (int i = 0; i < 6; i++) exp_pc.push_back(64'h100 + 64'(4 * i));
    for (int cyc = 0; cyc < 40 && exp_pc.size() != 0; cyc++) begin
      drive_cycle(acc);
      if (acc) begin
        checks++;
        if (exp_req.size() == 0) begin
          errors++; $display("[TB] FAIL seq_req unexpected addr=%h", ImemReqAddr);
        end else begin
          e = exp_req.pop_front();
          if (ImemReqAddr !== e) begin
            errors++; $display("[TB] FAIL seq_req got=%h exp=%h", ImemReqAddr, e);
          end
        end
        checks++;
        if (cyc - last_acc != 2) begin
          errors++; $display("[TB] FAIL seq_cadence got=%0d exp=2 cycles", cyc - last_acc);
        end
        last_acc = cyc;
      end
      if (InstrValid && InstrReady) begin
        checks++;
        if (exp_pc.size() == 0) begin
          errors++; $display("[TB] FAIL seq_instr unexpected pc=%h", InstrPC);
        end else begin
          e = exp_pc.pop_front();
          if (InstrPC !== e || Instr !== mem_data(e)) begin
            errors++; $display("[TB] FAIL seq_instr got=%h/%h exp=%h/%h", InstrPC, Instr, e, mem_data(e));
          end
        end
      end
    end
    checks++;
    if (exp_pc.size() != 0) begin
      errors++; $display("[TB] FAIL seq_timeout left=%0d exp=0", exp_pc.size());
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    logic [63:0] e;
    int n_acc = 0;
    do_reset(64'h100);
    exp_req = '{64'h100, 64'h104, 64'h108, 64'h10C, 64'h110};
    exp_pc  = '{64'h100, 64'h104, 64'h108};
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive_cycle(acc);
      InstrReady = 1'b0;
      if (acc) begin
        n_acc++;
        checks++;
        e = exp_req.pop_front();
        if (ImemReqAddr !== e) begin
          errors++; $display("[TB] FAIL bp_req got=%h exp=%h", ImemReqAddr, e);
        end
      end
    end
    checks++;
    if (n_acc != 2) begin
      errors++; $display("[TB] FAIL bp_credit got=%0d requests exp=2", n_acc);
    end
    checks++;
    if (ImemReqValid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_req_valid got=%b exp=0", ImemReqValid);
    end
    checks++;
    if (InstrValid !== 1'b1 || InstrPC !== 64'h100 || Instr !== mem_data(64'h100)) begin
      errors++; $display("[TB] FAIL bp_head got=%b/%h/%h exp=1/%h/%h", InstrValid, InstrPC, Instr, 64'h100, mem_data(64'h100));
    end
    for (int cyc = 0; cyc < 20 && exp_pc.size() != 0; cyc++) begin
      drive_cycle(acc);
      InstrReady = 1'b1;
      if (acc) begin
        checks++;
        if (exp_req.size() == 0) begin
          errors++; $display("[TB] FAIL bp_drain_req unexpected addr=%h", ImemReqAddr);
        end else begin
          e = exp_req.pop_front();
          if (ImemReqAddr !== e) begin
            errors++; $display("[TB] FAIL bp_drain_req got=%h exp=%h", ImemReqAddr, e);
          end
        end
      end
      if (InstrValid && InstrReady) begin
        checks++;
        e = exp_pc.pop_front();
        if (InstrPC !== e || Instr !== mem_data(e)) begin
          errors++; $display("[TB] FAIL bp_drain got=%h/%h exp=%h/%h", InstrPC, Instr, e, mem_data(e));
        end
      end
    end
    checks++;
    if (exp_pc.size() != 0) begin
      errors++; $display("[TB] FAIL bp_timeout left=%0d exp=0", exp_pc.size());
    end
  endtask

  task automatic test_redirect_wait();
    bit acc;
    logic [63:0] e;
    int n_acc = 0;
    int redir_cyc = -10;
    bit redir_next = 1'b0;
    bit redir_done = 1'b0;
    bit stale_seen = 1'b0;
    do_reset(64'h100);
    exp_req = '{64'h100, 64'h104, 64'h108, 64'h40, 64'h44, 64'h48};
    exp_pc  = '{64'h100, 64'h104};
    for (int cyc = 0; cyc < 40 && !(redir_done && exp_pc.size() == 0); cyc++) begin
      mem_lat = (n_acc == 2) ? 3 : 1;
      drive_cycle(acc);
      Redirect   = redir_next;
      RedirectPC = 64'h40;
      redir_next = 1'b0;
      InstrReady = (cyc == 4) || redir_done;
      if (Redirect) begin
        redir_cyc = cyc;
        exp_pc.delete();
        exp_pc.push_back(64'h40);
        exp_pc.push_back(64'h44);
      end
      if (resp_seen && resp_addr == 64'h108) stale_seen = 1'b1;
      if (cyc == redir_cyc + 1) begin
        checks++;
        if (InstrValid !== 1'b0) begin
          errors++; $display("[TB] FAIL rw_flush got=%b exp=0", InstrValid);
        end
      end
      if (acc) begin
        checks++;
        if (exp_req.size() == 0) begin
          errors++; $display("[TB] FAIL rw_req unexpected addr=%h", ImemReqAddr);
        end else begin
          e = exp_req.pop_front();
          if (ImemReqAddr !== e) begin
            errors++; $display("[TB] FAIL rw_req got=%h exp=%h", ImemReqAddr, e);
          end
        end
        if (ImemReqAddr == 64'h108) redir_next = 1'b1;
        if (ImemReqAddr == 64'h40) begin
          checks++;
          if (!stale_seen) begin
            errors++; $display("[TB] FAIL rw_early_req got=issued exp=after stale response");
          end
        end
        n_acc++;
      end
      if (InstrValid && InstrReady) begin
        checks++;
        if (exp_pc.size() == 0) begin
          errors++; $display("[TB] FAIL rw_instr unexpected pc=%h", InstrPC);
        end else begin
          e = exp_pc.pop_front();
          if (InstrPC !== e || Instr !== mem_data(e)) begin
            errors++; $display("[TB] FAIL rw_instr got=%h/%h exp=%h/%h", InstrPC, Instr, e, mem_data(e));
          end
        end
      end
      if (Redirect) redir_done = 1'b1;
    end
    Redirect = 1'b0;
    checks++;
    if (!redir_done || exp_pc.size() != 0) begin
      errors++; $display("[TB] FAIL rw_timeout left=%0d redirected=%b exp=0/1", exp_pc.size(), redir_done);
    end
  endtask

  task automatic test_redirect_corners();
    bit acc;
    logic [63:0] e;
    logic [63:0] tgt;
    for (int k = 0; k < 2; k++) begin
      tgt = (k == 0) ? 64'h80 : 64'h200;
      do_reset(64'h100);
      InstrReady = 1'b1;
      exp_req = '{64'h100, tgt, tgt + 64'd4, tgt + 64'd8, tgt + 64'd12};
      exp_pc  = '{tgt, tgt + 64'd4};
      for (int cyc = 0; cyc < 30 && exp_pc.size() != 0; cyc++) begin
        drive_cycle(acc);
        Redirect   = (cyc == k);
        RedirectPC = tgt;
        if (cyc == k + 1) begin
          checks++;
          if (InstrValid !== 1'b0 || ImemReqValid !== (k == 1)) begin
            errors++; $display("[TB] FAIL rc%0d_after got=%b/%b exp=0/%b", k, InstrValid, ImemReqValid, (k == 1));
          end
        end
        if (acc) begin
          checks++;
          if (exp_req.size() == 0) begin
            errors++; $display("[TB] FAIL rc%0d_req unexpected addr=%h", k, ImemReqAddr);
          end else begin
            e = exp_req.pop_front();
            if (ImemReqAddr !== e) begin
              errors++; $display("[TB] FAIL rc%0d_req got=%h exp=%h", k, ImemReqAddr, e);
            end
          end
        end
        if (InstrValid && InstrReady) begin
          checks++;
          e = exp_pc.pop_front();
          if (InstrPC !== e || Instr !== mem_data(e)) begin
            errors++; $display("[TB] FAIL rc%0d_instr got=%h/%h exp=%h/%h", k, InstrPC, Instr, e, mem_data(e));
          end
        end
      end
      Redirect = 1'b0;
      checks++;
      if (exp_pc.size() != 0) begin
        errors++; $display("[TB] FAIL rc%0d_timeout left=%0d exp=0", k, exp_pc.size());
      end
    end
  endtask

  task automatic test_wrap();
    bit acc;
    logic [63:0] e;
    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    InstrReady = 1'b1;
    exp_req = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4, 64'h8};
    exp_pc  = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
    for (int cyc = 0; cyc < 30 && exp_pc.size() != 0; cyc++) begin
      drive_cycle(acc);
      if (acc) begin
        checks++;
        if (exp_req.size() == 0) begin
          errors++; $display("[TB] FAIL wrap_req unexpected addr=%h", ImemReqAddr);
        end else begin
          e = exp_req.pop_front();
          if (ImemReqAddr !== e) begin
            errors++; $display("[TB] FAIL wrap_req got=%h exp=%h", ImemReqAddr, e);
          end
        end
      end
      if (InstrValid && InstrReady) begin
        checks++;
        e = exp_pc.pop_front();
        if (InstrPC !== e || Instr !== mem_data(e)) begin
          errors++; $display("[TB] FAIL wrap_instr got=%h/%h exp=%h/%h", InstrPC, Instr, e, mem_data(e));
        end
      end
    end
    checks++;
    if (exp_pc.size() != 0) begin
      errors++; $display("[TB] FAIL wrap_timeout left=%0d exp=0", exp_pc.size());
    end
  endtask

  task automatic test_mid_reset();
    bit acc;
    logic [63:0] e;
    int n_acc = 0;
    do_reset(64'h100);
    exp_req = '{64'h100, 64'h104};
    for (int cyc = 0; cyc < 4; cyc++) begin
      mem_lat = (n_acc == 1) ? 3 : 1;
      drive_cycle(acc);
      if (acc) begin
        n_acc++;
        checks++;
        e = exp_req.pop_front();
        if (ImemReqAddr !== e) begin
          errors++; $display("[TB] FAIL mr_pre_req got=%h exp=%h", ImemReqAddr, e);
        end
      end
    end
    checks++;
    if (InstrValid !== 1'b1 || ImemReqValid !== 1'b0) begin
      errors++; $display("[TB] FAIL mr_pre_state got=%b/%b exp=1/0", InstrValid, ImemReqValid);
    end
    // Reset lands while 0x104 is outstanding; its response must never be returned.
    Reset_L = 1'b0;
    StartPC = 64'h200;
    pend_v  = 1'b0;
    drive_cycle(acc);
    checks++;
    if (InstrValid !== 1'b0 || ImemReqValid !== 1'b0 || Instr !== 32'h0 || acc) begin
      errors++; $display("[TB] FAIL mr_after_reset got=%b/%b/%h exp=0/0/0", InstrValid, ImemReqValid, Instr);
    end
    Reset_L    = 1'b1;
    InstrReady = 1'b1;
    exp_req = '{64'h200, 64'h204, 64'h208};
    exp_pc  = '{64'h200, 64'h204};
    for (int cyc = 0; cyc < 30 && exp_pc.size() != 0; cyc++) begin
      drive_cycle(acc);
      if (cyc == 0) begin
        checks++;
        if (ImemReqValid !== 1'b1) begin
          errors++; $display("[TB] FAIL mr_first_req got=%b exp=1", ImemReqValid);
        end
      end
      if (acc) begin
        checks++;
        if (exp_req.size() == 0) begin
          errors++; $display("[TB] FAIL mr_req unexpected addr=%h", ImemReqAddr);
        end else begin
          e = exp_req.pop_front();
          if (ImemReqAddr !== e) begin
            errors++; $display("[TB] FAIL mr_req got=%h exp=%h", ImemReqAddr, e);
          end
        end
      end
      if (InstrValid && InstrReady) begin
        checks++;
        e = exp_pc.pop_front();
        if (InstrPC !== e || Instr !== mem_data(e)) begin
          errors++; $display("[TB] FAIL mr_instr got=%h/%h exp=%h/%h", InstrPC, Instr, e, mem_data(e));
        end
      end
    end
    checks++;
    if (exp_pc.size() != 0) begin
      errors++; $display("[TB] FAIL mr_timeout left=%0d exp=0", exp_pc.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_corners();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
